div_share_arbiter: RTL

//   Shares one iterative 32-bit divider among NUM_REQ requesters.

---
 rtl/div_share_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one iterative divider among NUM_REQ requesters.
// Exactly one operation is outstanding at a time; a watchdog turns a missing done into an error response.
module div_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 40
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [2*NUM_REQ-1:0]  req_op_i,
    input  logic [32*NUM_REQ-1:0] req_a_i,
    input  logic [32*NUM_REQ-1:0] req_b_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    input  logic [NUM_REQ-1:0]    rsp_ready_i,
    output logic [31:0]           rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  div_start_o,
    output logic [1:0]            div_op_o,
    output logic [31:0]           div_a_o,
    output logic [31:0]           div_b_o,
    input  logic                  div_done_i,
    input  logic [31:0]           div_result_i
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      data_q, data_d;
    logic             err_q, err_d;

    logic [1:0]       op_arr [NUM_REQ];
    logic [31:0]      a_arr  [NUM_REQ];
    logic [31:0]      b_arr  [NUM_REQ];

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op_i[2*gi +: 2];
            assign a_arr[gi]  = req_a_i[32*gi +: 32];
            assign b_arr[gi]  = req_b_i[32*gi +: 32];
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    op_d     = op_arr[grant_idx];
                    a_d      = a_arr[grant_idx];
                    b_d      = b_arr[grant_idx];
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done arriving on the timeout cycle still counts as success.
                if (div_done_i) begin
                    data_d  = div_result_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d  = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        div_start_o = 1'b0;
        if (state_q == S_IDLE && grant_found && !rst_i) begin
            req_ready_o = NUM_REQ'(1) << grant_idx;
        end
        if (state_q == S_RESP) begin
            rsp_valid_o = NUM_REQ'(1) << owner_q;
        end
        if (state_q == S_ISSUE) begin
            div_start_o = 1'b1;
        end
    end

    assign rsp_data_o = data_q;
    assign rsp_err_o  = err_q;
    assign div_op_o   = op_q;
    assign div_a_o    = a_q;
    assign div_b_o    = b_q;

endmodule
